// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A clock divider produces the pixel strobe; horizontal and vertical counters
// advance on that strobe. Sync, active-video and the line/frame start pulses
// are registered from the next-state counts so they line up with pixel_x and
// pixel_y in the same cycle.
module vga_timing_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 2,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP_C = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_C = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_q, video_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             tick;

  // Pixel strobe: last clk of each pixel, decoded from the registered divider.
  assign tick = (div_q == DIV_LAST);

  // Next-state: divider, raster counters, wrap pulses and decoded outputs.
  always_comb begin
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    x_d     = x_q;
    y_d     = y_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d    = '0;
        line_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d     = '0;
          frame_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hsync_d = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_d = (x_d < H_DISP_C) && (y_d < V_DISP_C);
  end

  // State registers; reset wins over any divider phase or count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign p_tick      = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign video_on    = video_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule
